// File: rtl/regfile_wb_if.sv
// rtl/regfile_wb_if.sv - writeback/load/read-port bundle between pipeline and register file
interface regfile_wb_if #(
   parameter int DW = 16,
   parameter int AW = 4
);
   logic          wb_en;
   logic [AW-1:0] wb_addr;
   logic [DW-1:0] wb_data;
   logic          t_wr_n;
   logic          t_in;
   logic          ld_issue;
   logic [AW-1:0] ld_dest;
   logic          ld_done;
   logic [DW-1:0] ld_data;
   logic [AW-1:0] rs_addr;
   logic [AW-1:0] rm_addr;
   logic [DW-1:0] rs_data;
   logic [DW-1:0] rm_data;
   logic          t_out;
   logic          ld_busy;
   logic          stall;

   modport master (
      output wb_en, wb_addr, wb_data, t_wr_n, t_in,
      output ld_issue, ld_dest, ld_done, ld_data, rs_addr, rm_addr,
      input  rs_data, rm_data, t_out, ld_busy, stall
   );

   modport slave (
      input  wb_en, wb_addr, wb_data, t_wr_n, t_in,
      input  ld_issue, ld_dest, ld_done, ld_data, rs_addr, rm_addr,
      output rs_data, rm_data, t_out, ld_busy, stall
   );
endinterface

// File: rtl/regfile_wb.sv
// rtl/regfile_wb.sv - architectural registers, T flag, writeback bypass and single-entry load scoreboard
module regfile_wb #(
   parameter int DW = 16,
   parameter int AW = 4
) (
   input logic          clk,
   input logic          rst,
   regfile_wb_if.slave  bus
);
   localparam int NREG = 11;

   logic [DW-1:0] regs [NREG];
   logic          t_q;
   logic          pend;
   logic          kill;
   logic [AW-1:0] pdest;

   logic          wb_valid;
   logic          ld_commit;
   logic          rs_is_reg;
   logic          rm_is_reg;
   logic [DW-1:0] rs_store;
   logic [DW-1:0] rm_store;

   assign wb_valid  = bus.wb_en & (bus.wb_addr < AW'(NREG));
   assign ld_commit = pend & bus.ld_done & ~kill;
   assign rs_is_reg = bus.rs_addr < AW'(NREG);
   assign rm_is_reg = bus.rm_addr < AW'(NREG);

   always_comb begin
      rs_store = '0;
      rm_store = '0;
      for (int i = 0; i < NREG; i++) begin
         if (bus.rs_addr == AW'(i)) rs_store = regs[i];
         if (bus.rm_addr == AW'(i)) rm_store = regs[i];
      end
   end

   // ALU bypass beats load bypass: the ALU value is always the younger one
   assign bus.rs_data = !rs_is_reg                              ? '0          :
                        (wb_valid && bus.wb_addr == bus.rs_addr) ? bus.wb_data :
                        (ld_commit && pdest == bus.rs_addr)      ? bus.ld_data :
                                                                   rs_store;
   assign bus.rm_data = !rm_is_reg                              ? '0          :
                        (wb_valid && bus.wb_addr == bus.rm_addr) ? bus.wb_data :
                        (ld_commit && pdest == bus.rm_addr)      ? bus.ld_data :
                                                                   rm_store;

   assign bus.t_out   = !bus.t_wr_n ? bus.t_in : t_q;
   assign bus.ld_busy = pend;
   assign bus.stall   = pend & ~bus.ld_done & ~kill &
                        ((rs_is_reg & (bus.rs_addr == pdest)) |
                         (rm_is_reg & (bus.rm_addr == pdest)));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
         t_q   <= 1'b0;
         pend  <= 1'b0;
         kill  <= 1'b0;
         pdest <= '1;
      end else begin
         // Load write first so a same-cycle ALU write to the same register overrides it
         for (int i = 0; i < NREG; i++) begin
            if (ld_commit && pdest == AW'(i)) regs[i] <= bus.ld_data;
            if (wb_valid && bus.wb_addr == AW'(i)) regs[i] <= bus.wb_data;
         end

         if (!bus.t_wr_n) t_q <= bus.t_in;

         if (pend) begin
            if (bus.ld_done) begin
               pend <= bus.ld_issue;
               kill <= 1'b0;
               if (bus.ld_issue) pdest <= bus.ld_dest;
            end else if (wb_valid && bus.wb_addr == pdest) begin
               kill <= 1'b1;
            end
         end else if (bus.ld_issue) begin
            pend  <= 1'b1;
            pdest <= bus.ld_dest;
            kill  <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_regfile_wb.sv
// tb/tb_regfile_wb.sv - directed and randomized checks of regfile_wb against a behavioural model
module tb_regfile_wb;
   logic clk = 1'b0;
   logic rst;

   regfile_wb_if #(.DW(16), .AW(4)) bus ();

   regfile_wb #(.DW(16), .AW(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [15:0] m_r [11];
   logic        m_t;
   bit          m_pend;
   bit          m_stale;
   int          m_dest;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 11; i++) m_r[i] = 16'h0;
      m_t     = 1'b0;
      m_pend  = 1'b0;
      m_stale = 1'b0;
      m_dest  = 15;
   endtask

   function automatic logic [15:0] exp_rd(input int a);
      if (a > 10) return 16'h0;
      if (bus.wb_en && int'(bus.wb_addr) == a) return bus.wb_data;
      if (bus.ld_done && m_pend && !m_stale && m_dest == a) return bus.ld_data;
      return m_r[a];
   endfunction

   function automatic logic exp_stall();
      int rs = int'(bus.rs_addr);
      int rm = int'(bus.rm_addr);
      return m_pend && !bus.ld_done && !m_stale &&
             ((rs <= 10 && rs == m_dest) || (rm <= 10 && rm == m_dest));
   endfunction

   task automatic check_outputs(input string tag);
      chk({tag, ".rs_data"}, 32'(bus.rs_data), 32'(exp_rd(int'(bus.rs_addr))));
      chk({tag, ".rm_data"}, 32'(bus.rm_data), 32'(exp_rd(int'(bus.rm_addr))));
      chk({tag, ".t_out"},   32'(bus.t_out),   32'(!bus.t_wr_n ? bus.t_in : m_t));
      chk({tag, ".stall"},   32'(bus.stall),   32'(exp_stall()));
      chk({tag, ".ld_busy"}, 32'(bus.ld_busy), 32'(m_pend));
   endtask

   // Architectural effect of one rising edge, taken from the writeback and scoreboard rules
   task automatic model_commit();
      int wa = int'(bus.wb_addr);
      if (m_pend && bus.ld_done && !m_stale && m_dest <= 10) m_r[m_dest] = bus.ld_data;
      if (bus.wb_en && wa <= 10) m_r[wa] = bus.wb_data;
      if (!bus.t_wr_n) m_t = bus.t_in;
      if (m_pend) begin
         if (bus.ld_done) begin
            m_pend  = bus.ld_issue;
            m_stale = 1'b0;
            if (bus.ld_issue) m_dest = int'(bus.ld_dest);
         end else if (bus.wb_en && wa <= 10 && wa == m_dest) begin
            m_stale = 1'b1;
         end
      end else if (bus.ld_issue) begin
         m_pend  = 1'b1;
         m_dest  = int'(bus.ld_dest);
         m_stale = 1'b0;
      end
   endtask

   task automatic tick(input string tag);
      #1;
      check_outputs(tag);
      @(posedge clk);
      model_commit();
      @(negedge clk);
   endtask

   task automatic idle();
      bus.wb_en    = 1'b0;
      bus.wb_addr  = 4'h0;
      bus.wb_data  = 16'h0;
      bus.t_wr_n   = 1'b1;
      bus.t_in     = 1'b0;
      bus.ld_issue = 1'b0;
      bus.ld_dest  = 4'h0;
      bus.ld_done  = 1'b0;
      bus.ld_data  = 16'h0;
   endtask

   task automatic sweep(input string tag);
      for (int a = 0; a < 16; a++) begin
         bus.rs_addr = 4'(a);
         bus.rm_addr = 4'(15 - a);
         #1;
         check_outputs(tag);
      end
   endtask

   initial begin
      rst = 1'b0;
      idle();
      bus.rs_addr = 4'h0;
      bus.rm_addr = 4'h0;
      model_reset();
      @(negedge clk);
      @(negedge clk);

      // Reset state
      sweep("reset");
      chk("reset.stall", 32'(bus.stall), 32'h0);
      chk("reset.ld_busy", 32'(bus.ld_busy), 32'h0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      // Basic write then read next cycle
      bus.wb_en = 1'b1; bus.wb_addr = 4'd3; bus.wb_data = 16'h1234;
      tick("wr_r3");
      idle();
      bus.rs_addr = 4'd3;
      #1 chk("rd_r3", 32'(bus.rs_data), 32'h1234);
      tick("rd_r3_tick");

      // Same-cycle bypass of register and T
      bus.wb_en = 1'b1; bus.wb_addr = 4'd5; bus.wb_data = 16'hBEEF;
      bus.rm_addr = 4'd5; bus.t_wr_n = 1'b0; bus.t_in = 1'b1;
      #1;
      chk("bypass.rm", 32'(bus.rm_data), 32'hBEEF);
      chk("bypass.t", 32'(bus.t_out), 32'h1);
      tick("bypass");
      idle();

      // Write to an unmapped code
      bus.wb_en = 1'b1; bus.wb_addr = 4'd12; bus.wb_data = 16'h5555; bus.rs_addr = 4'd12;
      #1 chk("code12.rd", 32'(bus.rs_data), 32'h0);
      tick("code12");
      idle();
      sweep("after_code12");

      // Load-use stall and load completion bypass
      bus.ld_issue = 1'b1; bus.ld_dest = 4'd2;
      tick("ld2_issue");
      idle();
      bus.rs_addr = 4'd2; bus.rm_addr = 4'd0;
      #1;
      chk("ld2.stall", 32'(bus.stall), 32'h1);
      chk("ld2.busy", 32'(bus.ld_busy), 32'h1);
      tick("ld2_wait");
      bus.ld_done = 1'b1; bus.ld_data = 16'h00AA;
      #1;
      chk("ld2_done.stall", 32'(bus.stall), 32'h0);
      chk("ld2_done.rs", 32'(bus.rs_data), 32'h00AA);
      tick("ld2_done");
      idle();
      #1;
      chk("ld2_after.rs", 32'(bus.rs_data), 32'h00AA);
      chk("ld2_after.busy", 32'(bus.ld_busy), 32'h0);
      tick("ld2_after");

      // Kill: younger ALU write survives the stale load
      bus.ld_issue = 1'b1; bus.ld_dest = 4'd4;
      tick("ld4_issue");
      idle();
      bus.wb_en = 1'b1; bus.wb_addr = 4'd4; bus.wb_data = 16'h0007;
      tick("ld4_alu");
      idle();
      bus.ld_done = 1'b1; bus.ld_data = 16'hFFFF; bus.rs_addr = 4'd4;
      #1 chk("kill.done_rd", 32'(bus.rs_data), 32'h0007);
      tick("kill_done");
      idle();
      #1;
      chk("kill.r4", 32'(bus.rs_data), 32'h0007);
      chk("kill.busy", 32'(bus.ld_busy), 32'h0);
      tick("kill_after");

      // Same-cycle collision on SP
      bus.ld_issue = 1'b1; bus.ld_dest = 4'd8;
      tick("ld8_issue");
      idle();
      bus.ld_done = 1'b1; bus.ld_data = 16'h1111;
      bus.wb_en = 1'b1; bus.wb_addr = 4'd8; bus.wb_data = 16'h2222; bus.rs_addr = 4'd8;
      #1 chk("collide.bypass", 32'(bus.rs_data), 32'h2222);
      tick("collide");
      idle();
      #1 chk("collide.sp", 32'(bus.rs_data), 32'h2222);
      tick("collide_after");

      // Back-to-back completion and issue
      bus.ld_issue = 1'b1; bus.ld_dest = 4'd1;
      tick("ld1_issue");
      bus.ld_issue = 1'b1; bus.ld_dest = 4'd6;
      bus.ld_done = 1'b1; bus.ld_data = 16'h0101;
      tick("b2b");
      idle();
      bus.rs_addr = 4'd1; bus.rm_addr = 4'd6;
      #1;
      chk("b2b.busy", 32'(bus.ld_busy), 32'h1);
      chk("b2b.stall", 32'(bus.stall), 32'h1);
      chk("b2b.r1", 32'(bus.rs_data), 32'h0101);
      tick("b2b_wait");
      bus.ld_done = 1'b1; bus.ld_data = 16'h0606;
      tick("ld6_done");
      idle();
      #1 chk("b2b.r6", 32'(bus.rm_data), 32'h0606);
      tick("b2b_after");

      // Asynchronous reset between edges with a load pending
      bus.ld_issue = 1'b1; bus.ld_dest = 4'd7;
      tick("ld7_issue");
      idle();
      #2 rst = 1'b0;
      #1 chk("areset.busy", 32'(bus.ld_busy), 32'h0);
      model_reset();
      #1 rst = 1'b1;
      @(negedge clk);
      bus.ld_done = 1'b1; bus.ld_data = 16'hABCD; bus.rs_addr = 4'd7;
      tick("areset_done");
      idle();
      #1 chk("areset.r7", 32'(bus.rs_data), 32'h0);
      sweep("areset_sweep");
      @(negedge clk);

      // Randomized traffic
      for (int n = 0; n < 600; n++) begin
         bus.wb_en    = ($urandom_range(0, 2) == 0);
         bus.wb_addr  = 4'($urandom_range(0, 12));
         bus.wb_data  = 16'($urandom);
         bus.t_wr_n   = ($urandom_range(0, 3) != 0);
         bus.t_in     = 1'($urandom);
         bus.ld_issue = ($urandom_range(0, 2) == 0);
         bus.ld_dest  = 4'($urandom_range(0, 12));
         bus.ld_done  = ($urandom_range(0, 2) == 0);
         bus.ld_data  = 16'($urandom);
         bus.rs_addr  = 4'($urandom_range(0, 12));
         bus.rm_addr  = 4'($urandom_range(0, 15));
         tick("rand");
      end
      idle();
      sweep("final");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/regfile_wb.md
# regfile_wb

Register file and writeback stage of the 16-bit CPU. Sinks the ALU's result and T-flag outputs, plus load data returning from the memory stage. Commits both into the architectural registers (R0–R7, SP, IH, RA, T) and serves the two operand read ports that feed the ALU's `rs`/`rm` inputs. A single-entry load scoreboard drives `stall` on load-use hazards so that decode holds.

## Interface
Parameters:
- `DW`, 16: data width.
- `AW`, 4: register address width. Codes: 0–7 = R0–R7, 8 = SP, 9 = IH, 10 = RA, 11–15 = none.

Ports (name, direction, width, meaning):
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `wb_en`  in  1  ALU result write request.
- `wb_addr`  in  AW  ALU destination code.
- `wb_data`  in  DW  ALU `res`.
- `t_wr_n`  in  1  T-write strobe, active-low; T is updated when 0.
- `t_in`  in  1  new T value from the ALU.
- `ld_issue`  in  1  a load has been issued toward memory.
- `ld_dest`  in  AW  destination code of the issued load.
- `ld_done`  in  1  load data valid this cycle.
- `ld_data`  in  DW  returned load data.
- `rs_addr`, `rm_addr`  in  AW  read addresses.
- `rs_data`, `rm_data`  out  DW  read data, combinational.
- `t_out`  out  1  current T, with bypass.
- `ld_busy`  out  1  a load is outstanding.
- `stall`  out  1  load-use hazard on a read port.

## Operation
- State:
  - Registers R0–R7, SP, IH, RA, each DW bits.
  - T, 1 bit.
  - Scoreboard: `pend` (1 bit), `pdest` (AW bits), `kill` (1 bit).
- Reset (`rst`=0, asynchronous): every register, T, `pend` and `kill` go to 0; `pdest` goes to 4'hF.
  - Resulting outputs: `ld_busy`=0 and `stall`=0.
  - `rs_data`, `rm_data` and `t_out` follow the read rules below on the zeroed state.
- ALU write: when `wb_en`=1 and `wb_addr`≤10, `wb_data` is written to that register at the clock edge. Codes 11–15 are ignored.
- T write: when `t_wr_n`=0, T takes `t_in`. This is independent of `wb_en`.
- Load scoreboard (one outstanding load only):
  - Idle (`pend`=0):
    - `ld_issue`=1 sets `pend`, `pdest`←`ld_dest`, `kill`←0.
    - `ld_done` is ignored.
  - Pending (`pend`=1):
    - `ld_issue` is ignored; the issuer must respect `ld_busy`.
    - `ld_done`=1 writes `ld_data` to `pdest` unless `kill`=1, then clears `pend`.
    - `ld_done` and `ld_issue` in the same cycle: complete the current load, then accept the new one. Next state is `pend`=1 with the new `pdest`.
  - Kill: an ALU write to `pdest` while pending, with no `ld_done` that cycle, sets `kill`. The younger ALU value survives and the stale load data is discarded on completion.
  - Same-cycle collision: `ld_done` and `wb_en` target the same register. The ALU value is written (it is younger); the load data is dropped.
- Read rules, identical for both ports, highest priority first:
  1. Code 11–15 reads 0.
  2. If `wb_en`=1 and `wb_addr` matches, return `wb_data`.
  3. If `ld_done`=1, `pend`=1, `kill`=0 and `pdest` matches, return `ld_data`.
  4. Otherwise return the stored register.
- `t_out` = `t_in` when `t_wr_n`=0, else stored T.
- `stall` = `pend` & ~`ld_done` & ~`kill` & (`rs_addr`==`pdest` | `rm_addr`==`pdest`). Codes 11–15 never match.
- `ld_busy` = `pend`.

## Timing
- Write latency: 1 cycle. Data presented in cycle N is visible from storage in N+1, and via bypass within cycle N.
- Read ports, `t_out` and `stall` are purely combinational from the current inputs and state.
- The ALU drives its outputs on the falling edge. Inputs are therefore stable half a cycle before the rising-edge capture here.
- Reset asserted mid-load: the scoreboard clears immediately, and a later `ld_done` is ignored.
- A minimum load turnaround of 1 cycle is supported: `ld_issue` in cycle N, `ld_done` in N+1.

## Test plan
- Reset → all reads 0, `t_out`=0, `stall`=0, `ld_busy`=0. Write R3=16'h1234, then read `rs_addr`=3 next cycle → 16'h1234.
- Bypass: `wb_en`, `wb_addr`=5, `wb_data`=16'hBEEF with `rm_addr`=5 in the same cycle → `rm_data`=16'hBEEF. With `t_wr_n`=0 and `t_in`=1 → `t_out`=1 that cycle. A write to code 12 leaves all registers unchanged, and a read of 12 returns 0.
- Load-use: `ld_issue`, `ld_dest`=2, then `rs_addr`=2 → `stall`=1 and `ld_busy`=1. Then `ld_done`, `ld_data`=16'h00AA → `stall`=0 and `rs_data`=16'h00AA that cycle; R2=16'h00AA afterward.
- Kill: load pending to R4, then ALU writes R4=16'h0007 → `kill` set. `ld_done` with 16'hFFFF → R4 stays 16'h0007 and `ld_busy` drops.
- Collision: `ld_done` to SP with 16'h1111 plus `wb_en` SP=16'h2222 in the same cycle → SP=16'h2222. Back-to-back `ld_done`+`ld_issue` → `ld_busy` stays 1 with the new `pdest`.
- Asynchronous reset pulse between clock edges while a load is pending → `ld_busy`=0 immediately; a following `ld_done` alters no register.
